// File: rtl/acc_writeback.sv
// Accumulator writeback stage: clamps raw ALU results into ACC and executes SAV/SWP/CLR.
// The stage registers zero/neg from the next ACC value, so the flags always agree with ACC.
module acc_writeback #(
    parameter int DW   = 11,
    parameter int RW   = 12,
    parameter int MAXV = 999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [RW-1:0] alu_res,
    input  logic          hold,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] bak,
    output logic          zero,
    output logic          neg,
    output logic          sat,
    output logic          done
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_WR  = 3'd1,
        OP_SAV = 3'd2,
        OP_SWP = 3'd3,
        OP_CLR = 3'd4
    } op_e;

    localparam logic signed [RW-1:0] RES_MAX = RW'(MAXV);
    localparam logic signed [RW-1:0] RES_MIN = RW'(-MAXV);
    localparam logic [DW-1:0]        ACC_MAX = DW'(MAXV);
    localparam logic [DW-1:0]        ACC_MIN = DW'(-MAXV);

    logic signed [RW-1:0] res;
    logic                 accept;
    logic [DW-1:0]        acc_nx;
    logic [DW-1:0]        bak_nx;
    logic                 sat_nx;

    assign res      = alu_res;
    assign in_ready = ~hold;
    assign accept   = in_valid & ~hold;

    always_comb begin
        acc_nx = acc;
        bak_nx = bak;
        sat_nx = sat;
        if (accept) begin
            case (op)
                OP_WR: begin
                    if (res > RES_MAX) begin
                        acc_nx = ACC_MAX;
                        sat_nx = 1'b1;
                    end else if (res < RES_MIN) begin
                        acc_nx = ACC_MIN;
                        sat_nx = 1'b1;
                    end else begin
                        // In range, so the guard bit is a pure sign copy and can be dropped.
                        acc_nx = res[DW-1:0];
                        sat_nx = 1'b0;
                    end
                end
                OP_SAV: bak_nx = acc;
                OP_SWP: begin
                    acc_nx = bak;
                    bak_nx = acc;
                end
                OP_CLR: begin
                    acc_nx = '0;
                    sat_nx = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            bak  <= '0;
            zero <= 1'b1;
            neg  <= 1'b0;
            sat  <= 1'b0;
            done <= 1'b0;
        end else begin
            acc  <= acc_nx;
            bak  <= bak_nx;
            zero <= (acc_nx == '0);
            neg  <= acc_nx[DW-1];
            sat  <= sat_nx;
            done <= accept;
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// Directed bench for acc_writeback: clamp sweep, register ops, hold, flags and back-to-back.
module tb_acc_writeback;

    localparam int DW = 11;
    localparam int RW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [RW-1:0] alu_res;
    logic          hold;
    logic [DW-1:0] acc;
    logic [DW-1:0] bak;
    logic          zero;
    logic          neg;
    logic          sat;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    acc_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .alu_res  (alu_res),
        .hold     (hold),
        .acc      (acc),
        .bak      (bak),
        .zero     (zero),
        .neg      (neg),
        .sat      (sat),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sacc();
        return int'($signed(acc));
    endfunction

    function automatic int sbak();
        return int'($signed(bak));
    endfunction

    // Present one op on the negedge, let it be taken at the posedge, sample 1ns later.
    task automatic do_op(input logic [2:0] o, input int r);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        alu_res  = RW'(r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_check_done();
        @(posedge clk);
        #1;
        chk("done_idle", int'(done), 0);
    endtask

    task automatic chk_state(input string tag, input int a, input int b, input int z,
                             input int n, input int s, input int d);
        chk({tag, "_acc"},  sacc(),      a);
        chk({tag, "_bak"},  sbak(),      b);
        chk({tag, "_zero"}, int'(zero),  z);
        chk({tag, "_neg"},  int'(neg),   n);
        chk({tag, "_sat"},  int'(sat),   s);
        chk({tag, "_done"}, int'(done),  d);
    endtask

    int wr_in  [10] = '{3, 999, 1000, 1998, -9, -999, -1000, -1998, 2047, -2048};
    int wr_acc [10] = '{3, 999,  999,  999, -9, -999,  -999,  -999,  999,  -999};
    int wr_sat [10] = '{0,   0,    1,    1,  0,    0,     1,     1,    1,     1};

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; alu_res = '0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_state("rst", 0, 0, 1, 0, 0, 0);
        chk("rst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-cycle, right while done is high
        do_op(3'd1, 500);
        chk("pre_rst_acc", sacc(), 500);
        chk("pre_rst_done", int'(done), 1);
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // WR sweep, including boundaries
        for (int i = 0; i < 10; i++) begin
            do_op(3'd1, wr_in[i]);
            chk($sformatf("wr%0d_acc", i), sacc(), wr_acc[i]);
            chk($sformatf("wr%0d_sat", i), int'(sat), wr_sat[i]);
            chk($sformatf("wr%0d_neg", i), int'(neg), (wr_acc[i] < 0) ? 1 : 0);
            chk($sformatf("wr%0d_zero", i), int'(zero), 0);
            chk($sformatf("wr%0d_done", i), int'(done), 1);
            idle_check_done();
        end

        // SAV / SWP
        do_op(3'd1, 42);
        do_op(3'd2, 0);
        chk("sav_bak", sbak(), 42);
        do_op(3'd1, -7);
        do_op(3'd3, 0);
        chk_state("swp1", 42, -7, 0, 0, 0, 1);
        do_op(3'd3, 0);
        chk_state("swp2", -7, 42, 0, 1, 0, 1);
        idle_check_done();

        // Hold freezes the stage even with a valid WR presented
        @(negedge clk);
        hold = 1'b1; in_valid = 1'b1; op = 3'd1; alu_res = RW'(500);
        #1;
        chk("hold_ready", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_acc", i), sacc(), -7);
            chk($sformatf("hold%0d_done", i), int'(done), 0);
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("unhold_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_state("unhold", 500, 42, 0, 0, 0, 1);
        idle_check_done();

        // CLR and flags; SAV keeps sat
        do_op(3'd1, 1000);
        chk("clr_pre_sat", int'(sat), 1);
        do_op(3'd2, 0);
        chk_state("sav_sat", 999, 999, 0, 0, 1, 1);
        do_op(3'd4, 0);
        chk_state("clr", 0, 999, 1, 0, 0, 1);
        idle_check_done();

        // Reserved and NOP ops: no register change, done still pulses
        do_op(3'd1, -1);
        do_op(3'd6, 123);
        chk_state("rsv6", -1, 999, 0, 1, 0, 1);
        do_op(3'd7, 5);
        chk_state("rsv7", -1, 999, 0, 1, 0, 1);
        do_op(3'd0, 5);
        chk_state("nop", -1, 999, 0, 1, 0, 1);
        idle_check_done();

        // Back-to-back: each op sees the previous result
        do_op(3'd1, 10);
        chk("b2b0_acc", sacc(), 10);
        chk("b2b0_done", int'(done), 1);
        do_op(3'd1, -20);
        chk("b2b1_acc", sacc(), -20);
        chk("b2b1_done", int'(done), 1);
        do_op(3'd2, 0);
        chk("b2b2_bak", sbak(), -20);
        chk("b2b2_done", int'(done), 1);
        do_op(3'd4, 0);
        chk_state("b2b3", 0, -20, 1, 0, 0, 1);
        idle_check_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_writeback.md
Name: acc_writeback

Overview:
- Writeback stage directly downstream of the ALU op units (add/sub/neg/not): consumes the raw ALU result and commits it to the accumulator.
- Saturates results to the architectural range -999..+999 and holds ACC plus the backup register BAK.
- Implements the SAV/SWP/CLR register ops and publishes zero/negative flags for the jump logic.
- Feeds ACC back to the ALU operand input.

Parameters:
- DW, 11, architectural width of ACC/BAK (signed).
- RW, 12, width of raw ALU result (signed; one guard bit for add/sub overflow).
- MAXV, 999, saturation magnitude; clamp range is -MAXV..+MAXV.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result/op valid this cycle.
- in_ready  out  1  stage can accept; equals ~hold.
- op  in  3  0 NOP, 1 WR, 2 SAV, 3 SWP, 4 CLR, 5-7 reserved (treated as NOP).
- alu_res  in  RW  signed raw ALU result; used only by WR.
- hold  in  1  downstream stall (core blocked on port I/O); freezes the stage.
- acc  out  DW  current ACC, signed, registered.
- bak  out  DW  current BAK, signed, registered.
- zero  out  1  registered, acc==0.
- neg  out  1  registered, acc<0.
- sat  out  1  registered; 1 if the last accepted WR clamped.
- done  out  1  one-cycle pulse the cycle after any accepted transaction (including NOP/reserved).

Behaviour:
- Reset (async, any time, including mid-transaction): acc=0, bak=0, zero=1, neg=0, sat=0, done=0. The transaction in flight is dropped. First acceptance possible on the first rising edge after rst deasserts.
- Accept condition: in_valid && in_ready at a rising edge. in_ready = ~hold, combinational.
- While hold=1:
  - No state change, done=0.
  - in_valid and op are ignored.
  - The upstream stage must hold its inputs until accepted.
- Latency: 1 cycle. acc/bak/flags reflect an accepted op on the edge that accepts it. done is high during the following cycle.
- WR:
  - acc <= clamp(alu_res): if alu_res > MAXV then +MAXV; if alu_res < -MAXV then -MAXV; else alu_res truncated to DW bits (lossless inside range).
  - Comparison is signed at RW bits.
  - sat <= 1 iff a clamp occurred, else 0.
- SAV: bak <= acc; acc unchanged; sat unchanged.
- SWP: acc <= bak and bak <= acc on the same edge, using old values; sat unchanged.
- CLR: acc <= 0; bak unchanged; sat <= 0.
- NOP/reserved: no register change; done still pulses.
- Flags: zero/neg are recomputed from the new acc on every edge where acc may change, and always match acc in the same cycle.
- Back-to-back: a new op may be accepted every cycle. The second op sees the acc/bak written by the first.
- Boundary values:
  - alu_res = +999 or -999 is not saturated (sat=0).
  - +1000 and +2047 clamp to 999; -1000 and -2048 clamp to -999.
- No combinational path from alu_res to any output.

Test Plan:
- Reset: assert rst mid-cycle with acc=500 -> acc=0, bak=0, zero=1, neg=0, sat=0, done=0 immediately, without waiting for a clock edge.
- WR sweep: alu_res = 3, 999, 1000, 1998, -9, -999, -1000, -1998 -> acc = 3, 999, 999, 999, -9, -999, -999, -999. sat = 0,0,1,1,0,0,1,1. neg is set for the negative results, zero=0 throughout. done pulses once per op.
- SAV/SWP: WR 42, SAV, WR -7, SWP -> acc=42, bak=-7. A second SWP -> acc=-7, bak=42, neg=1.
- Hold: hold=1 with in_valid=1, WR 500 for 3 cycles -> in_ready=0, acc unchanged, no done. Deassert hold -> acc=500 next edge, exactly one done pulse.
- CLR/flags: WR 1000 (sat=1) then CLR -> acc=0, zero=1, sat=0, bak unchanged. A reserved op 6 leaves all registers unchanged but pulses done.
- Back-to-back: WR 10, WR -20, SAV, CLR on consecutive cycles -> acc=0, bak=-20, four done pulses in consecutive cycles.
